// File: rtl/mem_arbiter.sv
// Arbitrates one byte-wide RAM port between instruction fetch and load/store, sequencing 1/2/4-byte transfers.
// Loads and stores win over fetch unless fetch has been starved STARVE_LIMIT times; flush aborts fetch only.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [1:0]        lsu_size,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  state_t              state;
  logic [CW-1:0]       starve;
  logic                gnt_if;
  logic                xwe;
  logic [ADDR_W-1:0]   base;
  logic [2:0]          nbytes;
  logic [2:0]          step;
  logic [31:0]         wbuf;
  logic [31:0]         rbuf;

  logic                grant_if;
  logic                grant_lsu;
  logic [2:0]          lsu_n;
  logic [2:0]          cap_idx;
  logic [31:0]         rnext;

  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (lsu_req && (starve < LIMIT))
      grant_lsu = 1'b1;
    else if (if_req && !flush)
      grant_if = 1'b1;
    else if (lsu_req)
      grant_lsu = 1'b1;
  end

  always_comb begin
    case (lsu_size)
      2'b00:   lsu_n = 3'd1;
      2'b01:   lsu_n = 3'd2;
      default: lsu_n = 3'd4;
    endcase
  end

  // Read data lags the address by two edges, so step k captures byte k-2.
  always_comb begin
    cap_idx = step - 3'd2;
    rnext   = rbuf;
    rnext[{cap_idx[1:0], 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starve    <= '0;
      gnt_if    <= 1'b0;
      xwe       <= 1'b0;
      base      <= '0;
      nbytes    <= 3'd0;
      step      <= 3'd0;
      wbuf      <= 32'd0;
      rbuf      <= 32'd0;
      ram_addr  <= '0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      lsu_done  <= 1'b0;
      if_rdata  <= 32'd0;
      lsu_rdata <= 32'd0;
      busy      <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      lsu_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= grant_if | grant_lsu;
          if (!if_req || grant_if)
            starve <= '0;
          else if (grant_lsu && (starve < LIMIT))
            starve <= starve + CW'(1);

          if (grant_if || grant_lsu) begin
            state    <= XFER;
            gnt_if   <= grant_if;
            xwe      <= grant_lsu & lsu_we;
            base     <= grant_if ? if_addr : lsu_addr;
            nbytes   <= grant_if ? 3'd4 : lsu_n;
            wbuf     <= lsu_wdata;
            rbuf     <= 32'd0;
            step     <= 3'd1;
            ram_addr <= grant_if ? if_addr : lsu_addr;
            ram_wr   <= grant_lsu & lsu_we;
            if (grant_lsu && lsu_we)
              ram_dout <= lsu_wdata[7:0];
          end else begin
            state <= IDLE;
          end
        end

        XFER: begin
          if (gnt_if && flush) begin
            state  <= IDLE;
            ram_wr <= 1'b0;
            busy   <= 1'b0;
          end else if (xwe) begin
            step <= step + 3'd1;
            if (step == nbytes) begin
              ram_wr   <= 1'b0;
              lsu_done <= 1'b1;
              state    <= DONE;
            end else begin
              ram_addr <= base + ADDR_W'(step);
              ram_dout <= wbuf[{step[1:0], 3'b000} +: 8];
              ram_wr   <= 1'b1;
            end
          end else begin
            step <= step + 3'd1;
            if (step < nbytes)
              ram_addr <= base + ADDR_W'(step);
            if (step >= 3'd2)
              rbuf <= rnext;
            if (step == nbytes + 3'd1) begin
              state <= DONE;
              if (gnt_if) begin
                if_rdata <= rnext;
                if_done  <= 1'b1;
              end else begin
                lsu_rdata <= rnext;
                lsu_done  <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model, completion scoreboard, latency and protocol checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_wdata;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic        busy;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, preload port used only during reset
  logic [7:0]  mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_dat;

  always @(posedge clk) begin
    ram_din <= mem[ram_addr[15:0]];
    if (pl_en)
      mem[pl_addr] <= pl_dat;
    else if (ram_wr)
      mem[ram_addr[15:0]] <= ram_dout;
  end

  typedef struct packed {
    logic        is_if;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   nif = 0, nlsu = 0;
  int   t_if = 0, t_lsu = 0;
  bit   drop_lsu = 1'b1;
  logic prev_if = 1'b0, prev_lsu = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && if_done) begin
      chk("if_unexpected_done", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("if_order", 32'(mon_e.is_if), 32'd1);
        chk("if_rdata", if_rdata, mon_e.data);
      end
      chk("if_pulse_width", 32'(prev_if), 32'd0);
    end
    if (!rst && lsu_done) begin
      chk("lsu_unexpected_done", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("lsu_order", 32'(mon_e.is_if), 32'd0);
        chk("lsu_rdata", lsu_rdata, mon_e.data);
      end
      chk("lsu_pulse_width", 32'(prev_lsu), 32'd0);
    end
    prev_if  <= if_done;
    prev_lsu <= lsu_done;
  end

  task automatic tick();
    @(negedge clk);
    if (if_done) begin
      nif++;
      t_if = cyc;
      if_req = 1'b0;
    end
    if (lsu_done) begin
      nlsu++;
      t_lsu = cyc;
      if (drop_lsu) lsu_req = 1'b0;
    end
  endtask

  task automatic wait_counts(input int want_if, input int want_lsu, input int budget, input string tag);
    int n = 0;
    while ((nif < want_if || nlsu < want_lsu) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(nif >= want_if && nlsu >= want_lsu), 32'd1);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_dat  = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic lsu_issue(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    lsu_we = we; lsu_addr = a; lsu_size = sz; lsu_wdata = wd; lsu_req = 1'b1;
  endtask

  function automatic exp_t mk(input logic is_if, input logic [31:0] d);
    exp_t e;
    e.is_if = is_if;
    e.data  = d;
    return e;
  endfunction

  initial begin
    int c, bl, bi, n;
    logic wr_seen;
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h0; lsu_size = 2'b00; lsu_wdata = 32'h0;
    pl_en = 1'b0; pl_addr = 16'h0; pl_dat = 8'h0;
    repeat (2) @(negedge clk);

    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_lsu_done", 32'(lsu_done), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
    poke(16'h2004, 8'h5A); poke(16'h3000, 8'hFF); poke(16'h3001, 8'h80);
    rst = 1'b0;
    tick();

    // 1: word fetch
    c = cyc; if_addr = 32'h1000; if_req = 1'b1; sb.push_back(mk(1'b1, 32'h00000513));
    wr_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      wr_seen |= ram_wr;
      chk($sformatf("t1_addr%0d", k), ram_addr, 32'h1000 + 32'(k));
    end
    chk("t1_busy", 32'(busy), 32'd1);
    wait_counts(1, 0, 20, "t1_timeout");
    chk("t1_latency", 32'(t_if - c), 32'd6);
    chk("t1_no_write", 32'(wr_seen | ram_wr), 32'd0);
    tick();
    chk("t1_busy_after", 32'(busy), 32'd0);

    // 2: byte write
    c = cyc; lsu_issue(1'b1, 32'h2003, 2'b00, 32'h123456AB); sb.push_back(mk(1'b0, 32'h0));
    tick();
    chk("t2_wr", 32'(ram_wr), 32'd1);
    chk("t2_addr", ram_addr, 32'h2003);
    chk("t2_dout", 32'(ram_dout), 32'hAB);
    wait_counts(1, 1, 20, "t2_timeout");
    chk("t2_latency", 32'(t_lsu - c), 32'd2);
    chk("t2_wr_off", 32'(ram_wr), 32'd0);
    tick();
    chk("t2_mem2003", 32'(mem[16'h2003]), 32'hAB);
    chk("t2_mem2004", 32'(mem[16'h2004]), 32'h5A);

    // 3: simultaneous requests, LSU wins
    c = cyc; if_addr = 32'h1000; if_req = 1'b1; lsu_issue(1'b0, 32'h3000, 2'b01, 32'h0);
    sb.push_back(mk(1'b0, 32'h000080FF)); sb.push_back(mk(1'b1, 32'h00000513));
    wait_counts(2, 2, 40, "t3_timeout");
    chk("t3_lsu_latency", 32'(t_lsu - c), 32'd4);
    chk("t3_if_latency", 32'(t_if - c), 32'd10);
    tick();

    // 4: starvation limit with continuous LSU byte reads
    bl = nlsu; bi = nif; drop_lsu = 1'b0;
    if_addr = 32'h1000; if_req = 1'b1; lsu_issue(1'b0, 32'h3000, 2'b00, 32'h0);
    for (int k = 0; k < 4; k++) sb.push_back(mk(1'b0, 32'h000000FF));
    sb.push_back(mk(1'b1, 32'h00000513));
    sb.push_back(mk(1'b0, 32'h000000FF));
    n = 0;
    while ((nlsu < bl + 5 || nif < bi + 1) && n < 200) begin
      tick();
      n++;
      if (nlsu == bl + 5) lsu_req = 1'b0;
    end
    drop_lsu = 1'b1;
    chk("t4_lsu_count", 32'(nlsu - bl), 32'd5);
    chk("t4_if_count", 32'(nif - bi), 32'd1);
    tick();

    // 5: flush aborts fetch, pending store proceeds
    poke(16'h0000, 8'h00);
    c = cyc; if_addr = 32'h1000; if_req = 1'b1;
    tick();
    lsu_issue(1'b1, 32'h4000, 2'b10, 32'hCAFEF00D); sb.push_back(mk(1'b0, 32'h000000FF));
    tick();
    flush = 1'b1; if_req = 1'b0;
    tick();
    flush = 1'b0;
    chk("t5_busy_drop", 32'(busy), 32'd0);
    chk("t5_no_if_done", 32'(if_done), 32'd0);
    tick();
    chk("t5_lsu_grant_busy", 32'(busy), 32'd1);
    chk("t5_lsu_grant_addr", ram_addr, 32'h4000);
    bl = nlsu;
    wait_counts(0, bl + 1, 20, "t5_timeout");
    chk("t5_latency", 32'(t_lsu - c), 32'd8);
    tick();
    chk("t5_mem_word", {mem[16'h4003], mem[16'h4002], mem[16'h4001], mem[16'h4000]}, 32'hCAFEF00D);

    // 6: asynchronous reset in the middle of a word write
    bl = nlsu;
    lsu_issue(1'b1, 32'h5000, 2'b10, 32'h11223344);
    tick();
    tick();
    chk("t6_wr_before", 32'(ram_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_ram_wr", 32'(ram_wr), 32'd0);
    chk("t6_ram_addr", ram_addr, 32'h0);
    chk("t6_ram_dout", 32'(ram_dout), 32'h0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_lsu_rdata", lsu_rdata, 32'h0);
    chk("t6_if_rdata", if_rdata, 32'h0);
    lsu_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("t6_no_done", 32'(nlsu - bl), 32'd0);
    c = cyc; lsu_issue(1'b0, 32'h3001, 2'b00, 32'h0); sb.push_back(mk(1'b0, 32'h00000080));
    wait_counts(0, bl + 1, 20, "t6_timeout");
    chk("t6_latency", 32'(t_lsu - c), 32'd3);
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-wide RAM port between the instruction-fetch requester (IF) and the load/store requester (LSU). It arbitrates, then sequences each granted transaction as 1, 2 or 4 consecutive byte accesses, assembling or splitting little-endian data. Data accesses have priority over fetch, and a starvation counter guarantees fetch progress. Branch flush aborts in-flight fetches only.

Parameters:
ADDR_W, 32, address width of requesters and RAM port
STARVE_LIMIT, 4, consecutive LSU grants allowed while if_req is pending before IF is forced

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  branch misprediction; kills IF traffic
if_req  in  1  fetch request; held with if_addr stable until if_done
if_addr  in  ADDR_W  fetch byte address (always 4-byte read)
if_done  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched word, held until next IF completion
lsu_req  in  1  data request; held with fields stable until lsu_done
lsu_we  in  1  1=write, 0=read
lsu_addr  in  ADDR_W  data byte address
lsu_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
lsu_wdata  in  32  write data, low bytes used
lsu_done  out  1  one-cycle pulse; transaction complete
lsu_rdata  out  32  read data zero-extended, held until next LSU read completion
ram_din  in  8  RAM read byte
ram_dout  out  8  RAM write byte
ram_addr  out  ADDR_W  RAM address
ram_wr  out  1  RAM write enable
busy  out  1  high from grant edge through done cycle

Behaviour:
- All outputs are registered. Reset values: ram_addr 0, ram_dout 0, ram_wr 0, if_done 0, lsu_done 0, if_rdata 0, lsu_rdata 0, busy 0. Starvation counter is 0 and the state is IDLE.
- RAM timing: the byte at the address driven during cycle n appears on ram_din during cycle n+1. A write is committed for every cycle in which ram_wr is high.
- States: IDLE, XFER, DONE.
- Arbitration in IDLE, sampled at edge E0:
  - If lsu_req is high and the counter is below STARVE_LIMIT, grant LSU.
  - Otherwise, if if_req is high and flush is low, grant IF.
  - Otherwise, if lsu_req is high, grant LSU. This covers the case where the counter is at the limit but IF is blocked or absent.
- Starvation counter: increments on an LSU grant while if_req is high. It clears on an IF grant, or at any arbitration where if_req is low. It saturates at STARVE_LIMIT.
- Byte count N: 1, 2 or 4 (IF is always 4). Byte k uses address base+k, with ADDR_W-bit wrap-around.
- Read sequencing:
  - At E_k (k = 0..N-1), ram_addr is set to base+k with ram_wr=0.
  - Byte k is captured from ram_din at E_(k+2) into bits [8k+7:8k].
  - At E_(N+1), the final rdata is registered and done goes high for one cycle (DONE).
  - Word read: done at E5. Byte read: done at E2.
- Write sequencing:
  - At E_k, ram_addr=base+k, ram_dout=wdata[8k+7:8k], ram_wr=1.
  - At E_N, ram_wr=0 and lsu_done goes high.
  - Word write: done at E4. Byte write: done at E1. lsu_rdata is unchanged by writes.
- DONE lasts exactly one cycle with no arbitration. Re-arbitration happens at the edge ending the DONE cycle, so a requester must drop req or present a new request by then.
- Flush:
  - Sampled high while an IF transaction is in XFER: at that edge go to IDLE, set ram_wr=0, and do not update if_rdata or pulse if_done. busy drops.
  - A flush that coincides with the IF DONE cycle does not cancel the pulse.
  - Flush never affects LSU transactions.
- Reset mid-transaction: outputs go to reset values immediately (asynchronous). The transaction is lost and no done pulse follows.
- Illegal lsu_size=11 behaves exactly as 10.

Test Plan:
1. RAM[0x1000..0x1003]=13 05 00 00; if_req at 0x1000 sampled at E0 -> ram_addr 0x1000..0x1003 at E0..E3; if_done single cycle at E5; if_rdata=0x00000513; ram_wr never high.
2. lsu_we=1, size=00, addr=0x2003, wdata=0x123456AB -> one ram_wr cycle with addr 0x2003 and dout 0xAB; lsu_done at E1; RAM 0x2004 untouched.
3. if_req and lsu_req (half read at 0x3000 holding 0xFF 0x80) rise together -> LSU first, lsu_rdata=0x000080FF at E3; IF is granted at the edge after DONE.
4. lsu_req held continuously (byte reads) and if_req held, STARVE_LIMIT=4 -> exactly 4 lsu_done pulses, then the IF word fetch, then LSU resumes.
5. flush pulsed at E2 of an IF fetch with LSU pending -> no if_done, busy falls, LSU is granted at the next edge and completes normally.
6. rst asserted mid-cycle during an LSU word write after E1 -> ram_wr falls within the same cycle, all outputs go to zero, no lsu_done; the next request after reset is served normally.
